dmod_serializer: RTL
====================

// Module: dmod_serializer
// PURPOSE
//  Downstream stage of the data_mod output: captures 5-bit dmod symbols strobed by mod_en,
//  buffers them in a small FIFO and emits a framed serial bitstream (preamble + FRAME_SYMS
//  symbols, MSB first) for the line driver. No backpressure exists upstream; overflow is flagged.
// PARAMETERS
//  SYM_W      5      symbol width (matches dmod)
//  DEPTH      8      symbol FIFO depth, power of 2, >=2
//  FRAME_SYMS 16     symbols per frame, >=1
//  PRE_W      8      preamble length in bits
//  PREAMBLE   8'hA5  preamble pattern, sent MSB first
// PORTS
//  clk        in   1               system clock, all logic on rising edge
//  reset      in   1               synchronous reset, active-high
//  dmod       in   SYM_W           symbol from data_mod
//  mod_en     in   1               symbol valid strobe, one symbol per high cycle
//  tx_bit     out  1               serial data
//  tx_valid   out  1               tx_bit meaningful this cycle
//  tx_sof     out  1               high with first preamble bit of each frame
//  busy       out  1               FSM not in IDLE
//  ovf        out  1               sticky: symbol dropped on full FIFO
//  fifo_level out  $clog2(DEPTH)+1 symbols currently buffered
// BEHAVIOUR
//  - Reset (synchronous, active-high): tx_bit=0, tx_valid=0, tx_sof=0, busy=0, ovf=0,
//    fifo_level=0, FIFO pointers cleared, FSM->IDLE. Reset mid-frame aborts the frame at once;
//    buffered symbols are discarded.
//  - All outputs registered.
//  - FIFO write: mod_en=1 and (not full, or pop in same cycle). Full with no pop: symbol dropped,
//    ovf set, stays 1 until reset. Simultaneous push+pop: level unchanged.
//  - FSM states: IDLE, PRE, DATA, PAR (parity build only), GAP.
//    IDLE: fifo_level>0 -> PRE; bit counter loaded with PRE_W-1.
//    PRE: drive PREAMBLE[cnt], tx_valid=1; tx_sof=1 on first bit only; after PRE_W bits -> DATA.
//    DATA: on symbol boundary pop FIFO head into shift reg, shift SYM_W bits MSB first,
//      tx_valid=1. If FIFO empty at boundary: stall with tx_valid=0, tx_bit=0; symbol count
//      not advanced; resume on first push. After last bit -> PAR if parity, else next symbol.
//      After FRAME_SYMS symbols -> GAP.
//    GAP: one cycle tx_valid=0 -> IDLE; a new frame can start the next cycle.
//  - Latency: mod_en at cycle t into empty FIFO in IDLE -> tx_sof/first preamble bit at
//    cycle t+2; first symbol bit at t+2+PRE_W.
//  - Symbol counter width $clog2(FRAME_SYMS+1); bit counter wraps per symbol/preamble.
//  - Frame bits without parity: PRE_W + FRAME_SYMS*SYM_W (+ stalls).
// CONFIGURATION
//  DMOD_SER_PARITY_EN defined: after every symbol, one PAR cycle sending even parity
//    (XOR of the SYM_W symbol bits), tx_valid=1; frame = PRE_W + FRAME_SYMS*(SYM_W+1) bits.
//  Not defined: no PAR state, symbols sent back to back.
// TESTING
//  1 Reset: assert reset 3 cycles mid-frame -> next cycle all outputs 0, fifo_level=0, busy=0.
//  2 Single frame: FRAME_SYMS=2, push 5'h1B,5'h04 -> tx_sof at t+2, bits 10100101 11011 00100,
//    then one tx_valid=0 GAP cycle, busy=0.
//  3 Underrun: push 1 symbol, FRAME_SYMS=2, push 2nd 10 cycles later -> tx_valid=0 during wait,
//    2nd symbol follows intact, single tx_sof.
//  4 Overflow: DEPTH=8, hold mod_en 12 cycles from IDLE -> ovf=1 sticky, first 8+pops sent,
//    no corruption of accepted symbols.
//  5 Full push+pop same cycle: level stays 8, ovf stays 0.
//  6 DMOD_SER_PARITY_EN: symbol 5'h1B -> bits 11011 then parity 0; 5'h04 -> 00100 then 1.

Source files
------------

// File: rtl/dmod_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : dmod_serializer_if
// Brief    : Symbol input strobe and framed serial line output of dmod_serializer.
// Revision : 1.0
// ============================================================================
interface dmod_serializer_if #(
    parameter int SYM_W = 5
);
    logic [SYM_W-1:0] dmod;
    logic             mod_en;
    logic             tx_bit;
    logic             tx_valid;
    logic             tx_sof;

    // master: symbol source plus line-side observer; slave: the serializer itself
    modport master (
        output dmod,
        output mod_en,
        input  tx_bit,
        input  tx_valid,
        input  tx_sof
    );

    modport slave (
        input  dmod,
        input  mod_en,
        output tx_bit,
        output tx_valid,
        output tx_sof
    );
endinterface
`default_nettype wire

// File: rtl/dmod_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dmod_serializer
// Brief    : Buffers dmod symbols in a FIFO and emits preamble-framed MSB-first
//            serial frames. Define DMOD_SER_PARITY_EN to append an even-parity
//            bit after every symbol.
// Revision : 1.0
// ============================================================================
module dmod_serializer #(
    parameter int              SYM_W      = 5,
    parameter int              DEPTH      = 8,
    parameter int              FRAME_SYMS = 16,
    parameter int              PRE_W      = 8,
    parameter logic [PRE_W-1:0] PREAMBLE  = 8'hA5
) (
    input  wire logic              clk,
    input  wire logic              reset,
    dmod_serializer_if.slave       bus,
    output logic                   busy,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int SCW  = $clog2(FRAME_SYMS + 1);
    localparam int MAXB = (PRE_W > SYM_W) ? PRE_W : SYM_W;
    localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;

`ifdef DMOD_SER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_PAR  = 3'd3,
        S_GAP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_GAP  = 3'd4
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [SYM_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q;
    logic             push, pop, full;
    logic [SYM_W-1:0] head;

    // Framing FSM
    state_t           state_q, state_d;
    logic [BCW-1:0]   cnt_q, cnt_d;
    logic [SCW-1:0]   sym_cnt_q, sym_cnt_d;
    logic [SYM_W-1:0] shift_q, shift_d;
    logic             stall_q, stall_d;
    logic             boundary;
`ifdef DMOD_SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // Registered line outputs
    logic tx_bit_q, tx_bit_d;
    logic tx_valid_q, tx_valid_d;
    logic tx_sof_q, tx_sof_d;
    logic busy_q;

    assign full    = (level_q == LW'(DEPTH));
    assign head    = mem_q[rd_ptr_q];
    assign push    = bus.mod_en && (!full || pop);
    assign level_d = level_q + LW'(push) - LW'(pop);

    // Outputs for the next cycle are decided here and registered, so the
    // registered state always describes the bit currently on the line.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sym_cnt_d  = sym_cnt_q;
        shift_d    = shift_q;
        stall_d    = stall_q;
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        tx_sof_d   = 1'b0;
        pop        = 1'b0;
        boundary   = 1'b0;
`ifdef DMOD_SER_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d    = S_PRE;
                    cnt_d      = BCW'(PRE_W - 1);
                    sym_cnt_d  = '0;
                    tx_bit_d   = PREAMBLE[PRE_W-1];
                    tx_valid_d = 1'b1;
                    tx_sof_d   = 1'b1;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    boundary = 1'b1;
                end else begin
                    cnt_d      = cnt_q - BCW'(1);
                    tx_bit_d   = PREAMBLE[cnt_q - BCW'(1)];
                    tx_valid_d = 1'b1;
                end
            end
            S_DATA: begin
                if (stall_q) begin
                    boundary = 1'b1;
                end else if (cnt_q == '0) begin
`ifdef DMOD_SER_PARITY_EN
                    state_d    = S_PAR;
                    tx_bit_d   = par_q;
                    tx_valid_d = 1'b1;
`else
                    boundary   = 1'b1;
`endif
                end else begin
                    cnt_d      = cnt_q - BCW'(1);
                    tx_bit_d   = shift_q[SYM_W-1];
                    shift_d    = shift_q << 1;
                    tx_valid_d = 1'b1;
                end
            end
`ifdef DMOD_SER_PARITY_EN
            S_PAR: begin
                boundary = 1'b1;
            end
`endif
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Symbol boundary: close the frame, start the next symbol, or wait
        // on an empty FIFO without advancing the symbol count.
        if (boundary) begin
            stall_d = 1'b0;
            if (sym_cnt_q == SCW'(FRAME_SYMS)) begin
                state_d = S_GAP;
            end else if (level_q != '0) begin
                pop        = 1'b1;
                state_d    = S_DATA;
                cnt_d      = BCW'(SYM_W - 1);
                sym_cnt_d  = sym_cnt_q + SCW'(1);
                tx_bit_d   = head[SYM_W-1];
                shift_d    = head << 1;
                tx_valid_d = 1'b1;
`ifdef DMOD_SER_PARITY_EN
                par_d      = ^head;
`endif
            end else begin
                state_d = S_DATA;
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sym_cnt_q  <= '0;
            shift_q    <= '0;
            stall_q    <= 1'b0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_sof_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
`ifdef DMOD_SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            shift_q    <= shift_d;
            stall_q    <= stall_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            tx_sof_q   <= tx_sof_d;
            busy_q     <= (state_d != S_IDLE);
            level_q    <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (bus.mod_en && full && !pop) begin
                ovf_q <= 1'b1;
            end
`ifdef DMOD_SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.dmod;
        end
    end

    assign bus.tx_bit   = tx_bit_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_sof   = tx_sof_q;
    assign busy         = busy_q;
    assign ovf          = ovf_q;
    assign fifo_level   = level_q;

endmodule
`default_nettype wire
